// File: rtl/seg7_scan_decoder.sv
// Recovers the four digit values shown on a multiplexed, active-low 7-segment display
// by sampling its segment and anode lines and capturing each scan slot once it has settled.
module seg7_scan_decoder #(
   parameter int unsigned SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   input  logic        e,
   input  logic        f,
   input  logic        g,
   input  logic [3:0]  an,
   output logic [15:0] o_digits,
   output logic [3:0]  o_blank,
   output logic [3:0]  o_valid,
   output logic        o_frame,
   output logic        o_seg_err,
   output logic        o_an_err
);

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   logic [3:0] an_reg;
   logic [6:0] seg_reg;
   logic [3:0] an_prev_reg;
   logic [6:0] seg_prev_reg;
   logic [7:0] cnt_reg;
   logic [7:0] cnt_next;
   logic       slot_event;

   logic [3:0] sel;
   logic [2:0] low_count;
   logic [3:0] dec_value;
   logic       dec_digit;
   logic       dec_blank;
   logic       capture;
   logic       seg_bad;
   logic       an_bad;
   logic [3:0] seen_reg;
   logic [3:0] seen_next;
   logic       frame_hit;
   logic       frame_reg;
   logic       seg_err_reg;
   logic       an_err_reg;

   // Two-deep sample pipeline: the stability test compares consecutive samples only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         an_reg       <= 4'b1111;
         seg_reg      <= 7'b1111111;
         an_prev_reg  <= 4'b1111;
         seg_prev_reg <= 7'b1111111;
         cnt_reg      <= '0;
      end else begin
         an_reg       <= an;
         seg_reg      <= {a, b, c, d, e, f, g};
         an_prev_reg  <= an_reg;
         seg_prev_reg <= seg_reg;
         cnt_reg      <= cnt_next;
      end
   end

   always_comb begin
      cnt_next = cnt_reg;
      if ({an_reg, seg_reg} != {an_prev_reg, seg_prev_reg}) begin
         cnt_next = 8'd1;
      end else if (cnt_reg != SETTLE_C) begin
         cnt_next = cnt_reg + 8'd1;
      end
   end

   // SETTLE is at least 2, so a reload to 1 can never be mistaken for reaching it.
   assign slot_event = (cnt_next == SETTLE_C) && (cnt_reg != SETTLE_C);

   assign sel       = ~an_reg;
   assign low_count = {2'b00, sel[0]} + {2'b00, sel[1]} + {2'b00, sel[2]} + {2'b00, sel[3]};

   always_comb begin
      dec_value = 4'h0;
      dec_digit = 1'b0;
      dec_blank = 1'b0;
      case (seg_reg)
         7'b0000001: begin dec_value = 4'd0; dec_digit = 1'b1; end
         7'b1001111: begin dec_value = 4'd1; dec_digit = 1'b1; end
         7'b0010010: begin dec_value = 4'd2; dec_digit = 1'b1; end
         7'b0000110: begin dec_value = 4'd3; dec_digit = 1'b1; end
         7'b1001100: begin dec_value = 4'd4; dec_digit = 1'b1; end
         7'b0100100: begin dec_value = 4'd5; dec_digit = 1'b1; end
         7'b0100000: begin dec_value = 4'd6; dec_digit = 1'b1; end
         7'b0001111: begin dec_value = 4'd7; dec_digit = 1'b1; end
         7'b0000000: begin dec_value = 4'd8; dec_digit = 1'b1; end
         7'b0000100: begin dec_value = 4'd9; dec_digit = 1'b1; end
         7'b1111111: begin dec_value = 4'hF; dec_blank = 1'b1; end
         default:    begin dec_value = 4'h0; end
      endcase
   end

   assign capture   = slot_event && (low_count == 3'd1) && (dec_digit || dec_blank);
   assign seg_bad   = slot_event && (low_count == 3'd1) && !(dec_digit || dec_blank);
   assign an_bad    = slot_event && (low_count > 3'd1);
   assign frame_hit = capture && ((seen_reg | sel) == 4'b1111);

   always_comb begin
      seen_next = seen_reg;
      if (capture) begin
         seen_next = frame_hit ? 4'b0000 : (seen_reg | sel);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         seen_reg    <= '0;
         frame_reg   <= 1'b0;
         seg_err_reg <= 1'b0;
         an_err_reg  <= 1'b0;
      end else begin
         seen_reg    <= seen_next;
         frame_reg   <= frame_hit;
         seg_err_reg <= seg_bad;
         an_err_reg  <= an_bad;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         logic [3:0] digit_reg;
         logic       blank_reg;
         logic       valid_reg;

         always_ff @(posedge clk) begin
            if (!rst) begin
               digit_reg <= 4'h0;
               blank_reg <= 1'b0;
               valid_reg <= 1'b0;
            end else if (capture && sel[gi]) begin
               digit_reg <= dec_value;
               blank_reg <= dec_blank;
               valid_reg <= 1'b1;
            end
         end

         assign o_digits[4*gi +: 4] = digit_reg;
         assign o_blank[gi]         = blank_reg;
         assign o_valid[gi]         = valid_reg;
      end
   endgenerate

   assign o_frame   = frame_reg;
   assign o_seg_err = seg_err_reg;
   assign o_an_err  = an_err_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a table of held scan slots plus hand-written
// sequences for settle latency and mid-scan reset.
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a, b, c, d, e, f, g;
   logic [3:0]  an;
   logic [15:0] o_digits;
   logic [3:0]  o_blank;
   logic [3:0]  o_valid;
   logic        o_frame;
   logic        o_seg_err;
   logic        o_an_err;

   int checks = 0;
   int errors = 0;
   int n_frame = 0;
   int n_seg_err = 0;
   int n_an_err = 0;
   int n_excl = 0;

   always #5 clk = ~clk;

   seg7_scan_decoder #(.SETTLE(4)) dut (
      .clk(clk), .rst(rst),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .an(an),
      .o_digits(o_digits), .o_blank(o_blank), .o_valid(o_valid),
      .o_frame(o_frame), .o_seg_err(o_seg_err), .o_an_err(o_an_err)
   );

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          hold;
      logic [15:0] digits;
      logic [3:0]  blank;
      logic [3:0]  valid;
      int          frames;
      int          seg_errs;
      int          an_errs;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(logic [3:0] v_an, logic [6:0] v_seg, int v_hold,
                               logic [15:0] v_digits, logic [3:0] v_blank, logic [3:0] v_valid,
                               int v_frames, int v_seg_errs, int v_an_errs);
      vec_t v;
      v.an = v_an; v.seg = v_seg; v.hold = v_hold;
      v.digits = v_digits; v.blank = v_blank; v.valid = v_valid;
      v.frames = v_frames; v.seg_errs = v_seg_errs; v.an_errs = v_an_errs;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] p_an, input logic [6:0] p_seg);
      an = p_an;
      {a, b, c, d, e, f, g} = p_seg;
   endtask

   // Advance n cycles, sampling outputs 1 ns after each rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (o_frame)   n_frame++;
         if (o_seg_err) n_seg_err++;
         if (o_an_err)  n_an_err++;
         if ((32'(o_frame) + 32'(o_seg_err) + 32'(o_an_err)) > 1) n_excl++;
      end
   endtask

   task automatic clear_counts();
      n_frame = 0; n_seg_err = 0; n_an_err = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " digits"}, 32'(o_digits), 32'h0);
      chk({tag, " blank"},  32'(o_blank), 32'h0);
      chk({tag, " valid"},  32'(o_valid), 32'h0);
      chk({tag, " pulses"}, {29'd0, o_frame, o_seg_err, o_an_err}, 32'h0);
   endtask

   initial begin
      vecs[0]  = mk(4'b1110, 7'b1001111,  6, 16'h0001, 4'h0, 4'h1, 0, 0, 0);
      vecs[1]  = mk(4'b1101, 7'b0010010,  6, 16'h0021, 4'h0, 4'h3, 0, 0, 0);
      vecs[2]  = mk(4'b1011, 7'b0000110,  6, 16'h0321, 4'h0, 4'h7, 0, 0, 0);
      vecs[3]  = mk(4'b0111, 7'b1001100,  6, 16'h4321, 4'h0, 4'hF, 1, 0, 0);
      vecs[4]  = mk(4'b1110, 7'b0100100,  6, 16'h4325, 4'h0, 4'hF, 0, 0, 0);
      vecs[5]  = mk(4'b1110, 7'b0100000,  6, 16'h4326, 4'h0, 4'hF, 0, 0, 0);
      vecs[6]  = mk(4'b1011, 7'b1111111,  6, 16'h4F26, 4'h4, 4'hF, 0, 0, 0);
      vecs[7]  = mk(4'b1101, 7'b1110000,  6, 16'h4F26, 4'h4, 4'hF, 0, 1, 0);
      vecs[8]  = mk(4'b1100, 7'b0001111, 10, 16'h4F26, 4'h4, 4'hF, 0, 0, 1);
      vecs[9]  = mk(4'b1111, 7'b0000000, 10, 16'h4F26, 4'h4, 4'hF, 0, 0, 0);
      vecs[10] = mk(4'b1101, 7'b0001111,  6, 16'h4F76, 4'h4, 4'hF, 0, 0, 0);
      vecs[11] = mk(4'b0111, 7'b0000000,  6, 16'h8F76, 4'h4, 4'hF, 1, 0, 0);
      vecs[12] = mk(4'b1011, 7'b0000100,  6, 16'h8976, 4'h0, 4'hF, 0, 0, 0);
      vecs[13] = mk(4'b1110, 7'b0100100,  6, 16'h8975, 4'h0, 4'hF, 0, 0, 0);

      drive(4'b1111, 7'b1111111);
      rst = 1'b0;
      step(2);
      chk_all_zero("reset");
      rst = 1'b1;
      step(2);

      for (int i = 0; i < 14; i++) begin
         clear_counts();
         drive(vecs[i].an, vecs[i].seg);
         step(vecs[i].hold);
         chk($sformatf("v%0d digits", i),   32'(o_digits), 32'(vecs[i].digits));
         chk($sformatf("v%0d blank", i),    32'(o_blank),  32'(vecs[i].blank));
         chk($sformatf("v%0d valid", i),    32'(o_valid),  32'(vecs[i].valid));
         chk($sformatf("v%0d frames", i),   n_frame,       vecs[i].frames);
         chk($sformatf("v%0d seg_errs", i), n_seg_err,     vecs[i].seg_errs);
         chk($sformatf("v%0d an_errs", i),  n_an_err,      vecs[i].an_errs);
         $display("vec %0d an=%b seg=%b digits=%h blank=%h valid=%h frames=%0d seg_err=%0d an_err=%0d",
                  i, vecs[i].an, vecs[i].seg, o_digits, o_blank, o_valid, n_frame, n_seg_err, n_an_err);
      end

      // A 3-sample interval must not capture; the following pattern captures on its 4th count.
      clear_counts();
      drive(4'b1110, 7'b0000001);
      step(3);
      drive(4'b1110, 7'b1001111);
      step(4);
      chk("short interval no capture", 32'(o_digits[3:0]), 32'h5);
      step(1);
      chk("settled capture", 32'(o_digits[3:0]), 32'h1);
      chk("settled no seg_err", n_seg_err, 0);
      chk("settled no frame", n_frame, 0);
      $display("settle seq digits=%h", o_digits);

      // Three slots of a frame seen, then a reset in the middle of a partial slot.
      clear_counts();
      drive(4'b0111, 7'b0000000);
      step(6);
      drive(4'b1101, 7'b0010010);
      step(3);
      rst = 1'b0;
      step(1);
      chk_all_zero("mid reset");
      rst = 1'b1;
      step(4);
      chk("post reset partial valid", 32'(o_valid), 32'h0);
      step(1);
      chk("post reset capture valid", 32'(o_valid), 32'h2);
      chk("post reset capture digits", 32'(o_digits), 32'h0020);
      drive(4'b1110, 7'b1001111);
      step(6);
      drive(4'b1011, 7'b0000110);
      step(6);
      chk("post reset no early frame", n_frame, 0);
      drive(4'b0111, 7'b1001100);
      step(6);
      chk("post reset frame", n_frame, 1);
      chk("post reset digits", 32'(o_digits), 32'h4321);
      chk("post reset valid", 32'(o_valid), 32'hF);
      $display("reset seq digits=%h valid=%h frames=%0d", o_digits, o_valid, n_frame);

      chk("pulse exclusivity", n_excl, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
